lsu_mem_responder: RTL and testbench

- Memory-side responder for the LSU request/response port. It accepts one request at a time (level-held `lsu_reqValid`), waits a programmable latency, then performs the read or masked write on an internal word array.
- Returns a single-cycle `lsu_respValid` pulse, with `lsu_rdata` on reads.
- Sits between the LSU and the data-memory slot. It doubles as the simulation/FPGA data RAM and as the bench target for LSU verification.

---
 rtl/lsu_mem_responder_pkg.sv | 30 +++
 rtl/lsu_mem_array.sv | 31 +++
 rtl/lsu_mem_responder.sv | 127 ++++++++++++
 tb/tb_lsu_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_responder_pkg.sv
`timescale 1ns/1ps
// Shared types for the LSU memory responder: size codes, FSM states, default base.
package lsu_mem_responder_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] LSU_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DROP = 2'd3
  } state_e;

  // Alignment/legality of an access size against the low address bits.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = lo[0];
      SZ_W:    err = |lo;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_mem_array.sv
`timescale 1ns/1ps
// Single-port DEPTH x 32 word RAM, byte write enables, registered read (1 cycle).
// No backpressure: every enabled cycle is serviced; rdat holds until the next read.
module lsu_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdat,
  output logic [31:0]   rdat
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdat_q;

  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
    if (en && !we) rdat_q <= mem_q[idx];
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/lsu_mem_responder.sv
`timescale 1ns/1ps
// LSU memory responder: one request at a time, response LATENCY+1 cycles after accept (+0..3 random).
// Request is level-held by the LSU; a new one is only accepted once reqValid drops after the response.
module lsu_mem_responder
  import lsu_mem_responder_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = LSU_BASE_ADDR,
  parameter int          LATENCY    = 1,
  parameter bit          RAND_DELAY = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_respErr,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lfsr_q, lfsr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          err_q, err_d;
  logic          rd_zero_q, rd_zero_d;

  logic [31:0]   off;
  logic          req_err;
  logic [1:0]    extra;
  logic          mem_en;
  logic [31:0]   ram_rdat;

  // DEPTH is a power of two, so off >= 4*DEPTH means any bit above the index is set.
  assign off     = lsu_addr - BASE_ADDR;
  assign req_err = (|(off >> (AW + 2))) | size_err(lsu_size, lsu_addr[1:0]);
  assign extra   = RAND_DELAY ? lfsr_q[1:0] : 2'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    idx_d     = idx_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    err_d     = err_q;
    rd_zero_d = rd_zero_q;
    mem_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_reqValid) begin
          idx_d   = off[AW+1:2];
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          err_d   = req_err;
          cnt_d   = CW'(LATENCY - 1) + CW'(extra);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_en    = ~err_q;
          rd_zero_d = err_q | wen_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = DROP;
      DROP:    if (!lsu_reqValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= 4'b1001;
      idx_q     <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      err_q     <= err_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  lsu_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clock (clock),
    .en    (mem_en),
    .we    (wen_q),
    .be    (wmask_q),
    .idx   (idx_q),
    .wdat  (wdata_q),
    .rdat  (ram_rdat)
  );

  assign lsu_respValid = (state_q == RESP);
  assign lsu_respErr   = (state_q == RESP) & err_q;
  assign lsu_rdata     = rd_zero_q ? 32'h0 : ram_rdat;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_mem_responder.sv
`timescale 1ns/1ps
// Bench: instance A (LATENCY=1, fixed delay) and B (LATENCY=4, random delay) against a word-array model.
module tb_lsu_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH_A = 1024;
  localparam int DEPTH_B = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b, rv_in_a, rv_in_b;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        wen;
  logic [3:0]  wmask;
  logic        rv_a, err_a, busy_a, rv_b, err_b, busy_b;
  logic [31:0] rdata_a, rdata_b;

  lsu_mem_responder #(.DEPTH(DEPTH_A), .BASE_ADDR(BASE), .LATENCY(1), .RAND_DELAY(1'b0)) u_dut_a (
    .clock(clock), .reset(rst_a), .lsu_reqValid(rv_in_a), .lsu_addr(addr), .lsu_size(size),
    .lsu_wen(wen), .lsu_wdata(wdata), .lsu_wmask(wmask), .lsu_respValid(rv_a),
    .lsu_rdata(rdata_a), .lsu_respErr(err_a), .busy(busy_a));

  lsu_mem_responder #(.DEPTH(DEPTH_B), .BASE_ADDR(BASE), .LATENCY(4), .RAND_DELAY(1'b1)) u_dut_b (
    .clock(clock), .reset(rst_b), .lsu_reqValid(rv_in_b), .lsu_addr(addr), .lsu_size(size),
    .lsu_wen(wen), .lsu_wdata(wdata), .lsu_wmask(wmask), .lsu_respValid(rv_b),
    .lsu_rdata(rdata_b), .lsu_respErr(err_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_m [2][16];
  bit          lat_seen [4];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz, input int depth);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'(4 * depth)) return 1'b1;
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Called and returns #1 after a rising edge with the target instance idle.
  task automatic do_req(input int inst, input logic [31:0] a, input logic [1:0] sz, input bit we,
                        input logic [31:0] wd, input logic [3:0] wm, input int hold,
                        output int lat, output bit e, output logic [31:0] rd, output int pulses);
    bit done;
    addr = a; size = sz; wen = we; wdata = wd; wmask = wm;
    if (inst == 0) rv_in_a = 1'b1; else rv_in_b = 1'b1;
    tick(1);
    // inputs after acceptance must be ignored
    addr = $urandom; size = 2'($urandom); wen = ~we; wdata = $urandom; wmask = 4'($urandom);
    lat = -1; e = 1'b0; rd = 32'hx; pulses = 0; done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      tick(1);
      if ((inst == 0) ? rv_a : rv_b) begin
        lat  = k + 1;
        e    = (inst == 0) ? err_a : err_b;
        rd   = (inst == 0) ? rdata_a : rdata_b;
        done = 1'b1;
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick(1);
      if ((inst == 0) ? rv_a : rv_b) pulses++;
    end
    if (inst == 0) rv_in_a = 1'b0; else rv_in_b = 1'b0;
    tick(2);
    chk_eq("busy_after_drop", 32'((inst == 0) ? busy_a : busy_b), 32'd0);
  endtask

  task automatic txn(input int inst, input logic [31:0] a, input logic [1:0] sz, input bit we,
                     input logic [31:0] wd, input logic [3:0] wm, input int hold,
                     output logic [31:0] rd);
    logic [31:0] off, rd_exp;
    bit e_exp, e;
    int lat, pulses, idx;
    off    = a - BASE;
    e_exp  = model_err(a, sz, (inst == 0) ? DEPTH_A : DEPTH_B);
    idx    = int'(off >> 2);
    rd_exp = 32'h0;
    if (!e_exp && !we) rd_exp = mem_m[inst][idx];
    do_req(inst, a, sz, we, wd, wm, hold, lat, e, rd, pulses);
    if (inst == 0) chk_eq("lat_a", 32'(lat), 32'd2);
    else begin
      chk_eq("lat_b_in_5_to_8", 32'(lat >= 5 && lat <= 8), 32'd1);
      if (lat >= 5 && lat <= 8) lat_seen[lat-5] = 1'b1;
    end
    chk_eq("resp_err", 32'(e), 32'(e_exp));
    chk_eq("rdata", rd, rd_exp);
    chk_eq("extra_pulses", 32'(pulses), 32'd0);
    if (!e_exp && we)
      for (int i = 0; i < 4; i++)
        if (wm[i]) mem_m[inst][idx][8*i +: 8] = wd[8*i +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic [1:0]  sz;
    int          r, pulses, spread;

    rst_a = 1'b0; rst_b = 1'b0; rv_in_a = 1'b0; rv_in_b = 1'b0;
    addr = '0; size = '0; wen = 1'b0; wdata = '0; wmask = '0;
    tick(3);
    chk_eq("rst_resp_valid", 32'(rv_a), 32'd0);
    chk_eq("rst_resp_err", 32'(err_a), 32'd0);
    chk_eq("rst_rdata", rdata_a, 32'd0);
    chk_eq("rst_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    tick(2);

    for (int i = 0; i < 16; i++) txn(0, BASE + 32'(4*i), 2'd2, 1'b1, $urandom, 4'hf, 0, rd);

    txn(0, 32'h8000_0010, 2'd2, 1'b1, 32'hDEAD_BEEF, 4'hf, 0, rd);
    txn(0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);
    chk_eq("word_readback", rd, 32'hDEAD_BEEF);

    txn(0, 32'h8000_0020, 2'd2, 1'b1, 32'h0, 4'hf, 0, rd);
    txn(0, 32'h8000_0021, 2'd0, 1'b1, 32'h0000_AB00, 4'b0010, 0, rd);
    txn(0, 32'h8000_0020, 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);
    chk_eq("byte_readback", rd, 32'h0000_AB00);

    txn(0, 32'h8000_0002, 2'd2, 1'b1, 32'hFFFF_FFFF, 4'hf, 0, rd);
    txn(0, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);
    txn(0, 32'h7FFF_FFFC, 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);
    txn(0, BASE + 32'(4*DEPTH_A), 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);
    txn(0, BASE + 32'(4*DEPTH_A - 4), 2'd2, 1'b1, 32'h1, 4'h0, 0, rd);
    txn(0, 32'h8000_0004, 2'd2, 1'b1, 32'h5555_AAAA, 4'h0, 0, rd);
    txn(0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 4'h0, 5, rd);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE + 32'(4*DEPTH_A) + ($urandom & 32'hFFFF);
      else             a = BASE - 32'd1 - 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
      txn(0, a, sz, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2), rd);
    end

    for (int i = 0; i < 4; i++) txn(1, BASE + 32'(4*i), 2'd2, 1'b1, $urandom, 4'hf, 0, rd);

    // Reset B two cycles after it accepts a write; the write must never land.
    addr = BASE; size = 2'd2; wen = 1'b1; wdata = 32'hCAFE_F00D; wmask = 4'hf;
    rv_in_b = 1'b1;
    tick(3);
    rst_b = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (rv_b) pulses++;
    end
    chk_eq("reset_b_busy", 32'(busy_b), 32'd0);
    chk_eq("reset_b_rdata", rdata_b, 32'd0);
    rv_in_b = 1'b0;
    tick(1);
    rst_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (rv_b) pulses++;
    end
    chk_eq("reset_mid_wait_pulses", 32'(pulses), 32'd0);
    txn(1, BASE, 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);

    for (int n = 0; n < 50; n++) begin
      tick($urandom_range(0, 3));
      txn(1, BASE + 32'(4*$urandom_range(0, 3)), 2'd2, 1'b0, 32'h0, 4'h0, 0, rd);
    end
    spread = 0;
    for (int i = 0; i < 4; i++) spread += int'(lat_seen[i]);
    chk_eq("rand_delay_varies", 32'(spread > 1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
